serial_paralelo: RTL

//  Serial-to-parallel receiver of the physical layer. Inverse of the paralelo_serial transmitter.

---
 rtl/phy_pkg.sv | 12 +
 rtl/detector_com.sv | 25 ++
 rtl/serial_paralelo.sv | 103 ++++++++++
 3 files changed

// File: rtl/phy_pkg.sv
// rtl/phy_pkg.sv - shared physical-layer constants and receiver state encoding
package phy_pkg;

    localparam logic [7:0] COM_SYMBOL = 8'hBC;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        SYNC   = 2'd1,
        LOCKED = 2'd2
    } state_t;

endpackage

// File: rtl/detector_com.sv
// rtl/detector_com.sv - MSB-first 8-bit shift register with COM symbol comparator
module detector_com #(
    parameter logic [7:0] COM_SYMBOL = phy_pkg::COM_SYMBOL
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       data_in,
    output logic [7:0] sr_next,
    output logic       is_com
);

    logic [7:0] r_sr;

    assign sr_next = {r_sr[6:0], data_in};
    assign is_com  = (sr_next == COM_SYMBOL);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sr <= 8'h00;
        end else begin
            r_sr <= sr_next;
        end
    end

endmodule

// File: rtl/serial_paralelo.sv
// rtl/serial_paralelo.sv - serial-to-parallel receiver: COM hunt, byte lock, byte delivery
module serial_paralelo #(
    parameter logic [7:0]  COM_SYMBOL = phy_pkg::COM_SYMBOL,
    parameter int unsigned LOCK_COUNT = 4
) (
    input  logic       clk_32f,
    input  logic       reset,
    input  logic       data_in,
    output logic [7:0] data_out,
    output logic       valid_out,
    output logic       active,
    output logic       byte_strobe
);

    import phy_pkg::*;

    localparam logic [3:0] LC = 4'(LOCK_COUNT);

    logic [7:0] w_sr_next;
    logic       w_is_com;

    state_t     r_state;
    logic [2:0] r_bit_cnt;
    logic [3:0] r_com_cnt;
    logic [7:0] r_data_out;
    logic       r_valid_out;
    logic       r_active;
    logic       r_byte_strobe;

    detector_com #(
        .COM_SYMBOL (COM_SYMBOL)
    ) u_detector_com (
        .clk     (clk_32f),
        .reset   (reset),
        .data_in (data_in),
        .sr_next (w_sr_next),
        .is_com  (w_is_com)
    );

    always_ff @(posedge clk_32f or posedge reset) begin
        if (reset) begin
            r_state       <= HUNT;
            r_bit_cnt     <= 3'd0;
            r_com_cnt     <= 4'd0;
            r_data_out    <= 8'h00;
            r_valid_out   <= 1'b0;
            r_active      <= 1'b0;
            r_byte_strobe <= 1'b0;
        end else begin
            r_byte_strobe <= 1'b0;
            case (r_state)
                HUNT: begin
                    // Any bit alignment may match; the match fixes the byte phase.
                    if (w_is_com) begin
                        r_bit_cnt <= 3'd0;
                        if (LC == 4'd1) begin
                            r_state   <= LOCKED;
                            r_com_cnt <= LC;
                            r_active  <= 1'b1;
                        end else begin
                            r_state   <= SYNC;
                            r_com_cnt <= 4'd1;
                        end
                    end
                end
                SYNC: begin
                    r_bit_cnt <= r_bit_cnt + 3'd1;
                    if (r_bit_cnt == 3'd7) begin
                        if (w_is_com) begin
                            if (r_com_cnt + 4'd1 >= LC) begin
                                r_state   <= LOCKED;
                                r_com_cnt <= LC;
                                r_active  <= 1'b1;
                            end else begin
                                r_com_cnt <= r_com_cnt + 4'd1;
                            end
                        end else begin
                            r_state   <= HUNT;
                            r_com_cnt <= 4'd0;
                        end
                    end
                end
                LOCKED: begin
                    r_bit_cnt <= r_bit_cnt + 3'd1;
                    if (r_bit_cnt == 3'd7) begin
                        r_data_out    <= w_sr_next;
                        r_valid_out   <= ~w_is_com;
                        r_byte_strobe <= 1'b1;
                    end
                end
                default: begin
                    r_state <= HUNT;
                end
            endcase
        end
    end

    assign data_out    = r_data_out;
    assign valid_out   = r_valid_out;
    assign active      = r_active;
    assign byte_strobe = r_byte_strobe;

endmodule
